// File: rtl/pulse_seq_pkg.sv
// Shared types and default sizing for the pulse sequencer.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_NUM_EDGES = 8;
  localparam int DEF_IDX_W     = 3;

endpackage

// File: rtl/pulse_sequencer_cmp.sv
// Unsigned magnitude comparator shared by the timing blocks.
// Purely combinational; a_gteq_b is the exact complement of a_lt_b.
module pulse_sequencer_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_lt_b,
  output logic             a_gteq_b
);

  assign a_lt_b   = (a < b);
  assign a_gteq_b = ~a_lt_b;

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable single-channel pulse generator: period counter vs. edge table,
// each match toggles pulse_out one cycle later; one-shot or looped periods.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_EDGES = DEF_NUM_EDGES,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IDX_W:0]   cfg_num_edges,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_loop,
  input  logic             start,
  input  logic             stop,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [WIDTH-1:0] count,
  output logic [IDX_W:0]   edge_idx
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   IDX_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IDX_W:0]   edge_idx_q, edge_idx_d;
  logic             pulse_q, pulse_d;
  logic             overrun_q, overrun_d;
  logic [IDX_W:0]   num_edges_q, num_edges_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] edge_tbl_q [NUM_EDGES];
  logic [WIDTH-1:0] edge_tbl_d [NUM_EDGES];

  logic             cmp_gteq;
  logic             cmp_lt_unused;
  logic             fire;
  logic             last_cycle;

  pulse_sequencer_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a        (count_q),
    .b        (edge_tbl_q[edge_idx_q[IDX_W-1:0]]),
    .a_lt_b   (cmp_lt_unused),
    .a_gteq_b (cmp_gteq)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    edge_idx_d  = edge_idx_q;
    pulse_d     = pulse_q;
    overrun_d   = overrun_q;
    num_edges_d = num_edges_q;
    period_d    = period_q;
    loop_d      = loop_q;
    edge_tbl_d  = edge_tbl_q;
    fire        = 1'b0;
    last_cycle  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) edge_tbl_d[cfg_addr] = cfg_data;
        // stop in the same cycle vetoes the start
        if (start && !stop) begin
          num_edges_d = cfg_num_edges;
          period_d    = cfg_period;
          loop_d      = cfg_loop;
          overrun_d   = 1'b0;
          count_d     = '0;
          edge_idx_d  = '0;
          pulse_d     = 1'b0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        fire = (edge_idx_q < num_edges_q) && cmp_gteq;
        // period 0 wraps to all-ones, giving a 2^WIDTH-cycle period
        last_cycle = (count_q == period_q - CNT_ONE);
        count_d = count_q + CNT_ONE;
        if (fire) begin
          pulse_d    = ~pulse_q;
          edge_idx_d = edge_idx_q + IDX_ONE;
        end
        if (stop) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          count_d = '0;
        end else if (last_cycle) begin
          if (edge_idx_d < num_edges_q) overrun_d = 1'b1;
          count_d = '0;
          pulse_d = 1'b0;
          if (loop_q) edge_idx_d = '0;
          else        state_d    = ST_FINISH;
        end
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      edge_idx_q  <= '0;
      pulse_q     <= 1'b0;
      overrun_q   <= 1'b0;
      num_edges_q <= '0;
      period_q    <= '0;
      loop_q      <= 1'b0;
      for (int i = 0; i < NUM_EDGES; i++) edge_tbl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      edge_idx_q  <= edge_idx_d;
      pulse_q     <= pulse_d;
      overrun_q   <= overrun_d;
      num_edges_q <= num_edges_d;
      period_q    <= period_d;
      loop_q      <= loop_d;
      edge_tbl_q  <= edge_tbl_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign overrun   = overrun_q;
  assign count     = count_q;
  assign edge_idx  = edge_idx_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with hand-computed pulse patterns.
module tb_pulse_sequencer;

  localparam int WIDTH = 16;
  localparam int IDX_W = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [IDX_W:0]   cfg_num_edges;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_loop;
  logic             start;
  logic             stop;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [WIDTH-1:0] count;
  logic [IDX_W:0]   edge_idx;

  int checks = 0;
  int errors = 0;

  pulse_sequencer #(
    .WIDTH     (WIDTH),
    .NUM_EDGES (8),
    .IDX_W     (IDX_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_num_edges (cfg_num_edges),
    .cfg_period    (cfg_period),
    .cfg_loop      (cfg_loop),
    .start         (start),
    .stop          (stop),
    .pulse_out     (pulse_out),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .count         (count),
    .edge_idx      (edge_idx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = a[IDX_W-1:0];
    cfg_data = d[WIDTH-1:0];
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic go(input int n, input int p, input logic l);
    cfg_num_edges = n[IDX_W:0];
    cfg_period    = p[WIDTH-1:0];
    cfg_loop      = l;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Walks RUN cycles from..n-1, expecting count = i % per and pulse_out = pat[i]
  task automatic expect_run(input string tag, input int from, input int n,
                            input int per, input logic [63:0] pat);
    for (int i = from; i < n; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), 32'(count), 32'(i % per));
      chk($sformatf("%s_pulse%0d", tag, i), 32'(pulse_out), 32'(pat[i]));
      tick();
    end
  endtask

  task automatic expect_finish(input string tag, input logic exp_ovr);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busyfin"}, 32'(busy), 32'd1);
    chk({tag, "_pulsefin"}, 32'(pulse_out), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_num_edges = '0; cfg_period = '0; cfg_loop = 1'b0;
    start = 1'b0; stop = 1'b0;
    #12;
    chk("rst_pulse", 32'(pulse_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_eidx", 32'(edge_idx), 32'd0);
    reset_n = 1'b1;
    tick();

    // One-shot toggling: edges 3 and 7 -> high on counts 4..7
    wr(0, 3); wr(1, 7);
    go(2, 10, 1'b0);
    chk("os_busy", 32'(busy), 32'd1);
    expect_run("os", 0, 10, 10, 64'h00F0);
    chk("os_eidx", 32'(edge_idx), 32'd2);
    expect_finish("os", 1'b0);

    // Looped: edge at 0 -> low on count 0, high on 1..3, three periods
    wr(0, 0);
    go(1, 4, 1'b1);
    expect_run("loop", 0, 12, 4, 64'hEEE);
    chk("loop_ovr", 32'(overrun), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_pulse", 32'(pulse_out), 32'd0);
    chk("stop_count", 32'(count), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    tick();
    chk("stop_done2", 32'(done), 32'd0);

    // Overrun: second edge (12) never reached within period 8
    wr(0, 2); wr(1, 12);
    go(2, 8, 1'b0);
    expect_run("ovr", 0, 8, 8, 64'hF8);
    expect_finish("ovr", 1'b1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Edge on the last cycle fires; the new start clears overrun
    wr(0, 9);
    go(1, 10, 1'b0);
    chk("last_ovr_clr", 32'(overrun), 32'd0);
    expect_run("last", 0, 10, 10, 64'h0);
    chk("last_eidx", 32'(edge_idx), 32'd1);
    expect_finish("last", 1'b0);

    // Equal entries: second fires one cycle after the first
    wr(0, 5); wr(1, 5);
    go(2, 10, 1'b0);
    expect_run("dup", 0, 10, 10, 64'h40);
    chk("dup_eidx", 32'(edge_idx), 32'd2);
    expect_finish("dup", 1'b0);

    // Table write and start during RUN are both ignored
    go(1, 8, 1'b0);
    chk("ign_cnt0", 32'(count), 32'd0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd1;
    start  = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    expect_run("ign", 1, 8, 8, 64'hC0);
    expect_finish("ign", 1'b0);

    // start + stop together in IDLE: stays IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    tick();
    chk("ss_busy2", 32'(busy), 32'd0);

    // No edges: period still runs and done fires
    go(0, 3, 1'b0);
    expect_run("none", 0, 3, 3, 64'h0);
    expect_finish("none", 1'b0);

    // Asynchronous reset mid-run at count 5 with pulse high
    wr(0, 2);
    go(1, 10, 1'b0);
    repeat (5) tick();
    chk("mid_count", 32'(count), 32'd5);
    chk("mid_pulse", 32'(pulse_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pulse", 32'(pulse_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_eidx", 32'(edge_idx), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_busy", 32'(busy), 32'd0);
    // Table cleared by reset: entry 0 reads as 0, so toggle seen at count 1
    go(1, 4, 1'b0);
    expect_run("post", 0, 4, 4, 64'hE);
    expect_finish("post", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Programmable single-channel timing-pulse generator built around the shared magnitude comparator.
- A WIDTH-bit period counter is compared each cycle against the next entry of a small edge-time table; each match toggles pulse_out.
- Supports one-shot or looped periods, a runtime stop, and overrun detection.
- Sits between the host configuration registers and the optical-timing output pins.

Parameters:
- WIDTH, 16, counter, edge-time and period width
- NUM_EDGES, 8, depth of edge-time table (power of 2)
- IDX_W, 3, log2(NUM_EDGES)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write strobe, edge table
- cfg_addr  in  IDX_W  edge table index
- cfg_data  in  WIDTH  edge time, in counts from period start
- cfg_num_edges  in  IDX_W+1  number of active edges, 0..NUM_EDGES
- cfg_period  in  WIDTH  period length in cycles; 0 means 2^WIDTH
- cfg_loop  in  1  1 = repeat periods until stop
- start  in  1  single-cycle run request
- stop  in  1  single-cycle abort request
- pulse_out  out  1  registered timing output
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when a one-shot run completes
- overrun  out  1  sticky: period ended with edges unfired; cleared by accepted start
- count  out  WIDTH  current period counter
- edge_idx  out  IDX_W+1  index of next edge to fire

Behaviour:
- Reset: state IDLE; pulse_out, busy, done, overrun = 0; count and edge_idx = 0; edge table = 0.
- Table writes: accepted only in IDLE; cfg_we while busy is ignored.
- Start: start in IDLE latches cfg_num_edges, cfg_period and cfg_loop into shadow registers, clears overrun and count, sets edge_idx = 0, and enters RUN on the next cycle. Start outside IDLE is ignored. If start and stop arrive together, stop wins and start is ignored.
- Per-cycle compare in RUN: the comparator receives a = count, b = table[edge_idx].
- Firing: if edge_idx < num_edges and a_gteq_b, pulse_out toggles and edge_idx increments at the next edge. At most one edge fires per cycle.
- Latency: pulse_out changes one cycle after count equals the edge time.
- Non-increasing table entries: they fire one cycle after the preceding edge. This is defined behaviour, not an error.
- Counter: increments each RUN cycle. The last cycle is count = period-1 (period 0 gives 2^WIDTH-1). An edge matching on the last cycle still fires.
- Period end:
  - If edges remain unfired after the last cycle, overrun is set.
  - Loop: count = 0, edge_idx = 0, pulse_out forced 0, stay in RUN.
  - One-shot: go to FINISH, pulse_out forced 0.
- FINISH: done = 1 for exactly one cycle, busy still 1, then IDLE.
- num_edges = 0: no toggles; the period still runs and done still fires.
- Stop in RUN: next cycle IDLE, pulse_out = 0, count = 0, no done. Overrun is retained.
- Reset mid-run: immediate return to reset values, including the table.
- busy = (state != IDLE).
- States: IDLE -> RUN (start), RUN -> RUN (loop wrap), RUN -> FINISH (one-shot end), RUN -> IDLE (stop), FINISH -> IDLE.

Decomposition:
- Shared package pulse_seq_pkg holds:
  - state enumeration (IDLE, RUN, FINISH)
  - default WIDTH / NUM_EDGES constants
- Sub-module: the existing comparator, instantiated once with WIDTH passed down. Its a_lt_b output is left unused.
- Edge table is an inline register array; no separate module.

Test Plan:
- One-shot, toggling: table {3,7}, num_edges=2, period=10, loop=0, start -> pulse_out high on count 4..7 and low from count 8; done pulses one cycle after count 9; overrun 0.
- Loop: table {0}, num_edges=1, period=4, loop=1 -> pulse_out 0 on count 0, 1 on count 1..3, forced 0 at each wrap; pattern repeats 3 periods; stop -> pulse_out 0 and busy 0 next cycle, no done.
- Overrun: table {2,12}, num_edges=2, period=8 -> one toggle at count 3; overrun=1 after period end; done still asserted; next start clears overrun.
- Boundary edges: table {9}, period=10 -> toggle fires on the last cycle. Table {5,5}, num_edges=2 -> pulse_out high only for count 6; low again at count 7.
- Control corners:
  - cfg_we during RUN does not alter the table (readback via a subsequent run).
  - start+stop in the same IDLE cycle -> remains IDLE.
  - start during RUN is ignored.
  - num_edges=0 with period=3 -> pulse_out stays 0; done after 3 cycles.
- Reset: assert reset_n=0 mid-RUN at count 5 -> all outputs 0 immediately (asynchronously); after release the block is IDLE and table entries read as 0 (a run with num_edges=1 toggles at count 1).
